rgb_to_luma: RTL and testbench



---
 rtl/rgb2y_pkg.sv | 50 +++++
 rtl/rgb_to_luma_sig_delay.sv | 39 +++
 rtl/rgb_to_luma.sv | 119 +++++++++++
 tb/tb_rgb_to_luma.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rgb2y_pkg.sv
// Shared constants for the RGB-to-luma converter: coefficient encodings per
// POWEREFF mode, fraction widths and accumulator sizing.
package rgb2y_pkg;

    localparam int MODE_MULT8  = 0;
    localparam int MODE_SHIFT4 = 1;
    localparam int MODE_SHIFT7 = 2;

    localparam int FRAC_MULT8  = 8;
    localparam int FRAC_SHIFT4 = 4;
    localparam int FRAC_SHIFT7 = 7;

    // Mode 0 numerators over 2^8
    localparam int M0_COEF_R = 77;
    localparam int M0_COEF_G = 150;
    localparam int M0_COEF_B = 29;

    // Mode 1 over 2^4: R = 4+1, G = 8+1, B = 2
    localparam int M1_R_SH_HI = 2;
    localparam int M1_R_SH_LO = 0;
    localparam int M1_G_SH_HI = 3;
    localparam int M1_G_SH_LO = 0;
    localparam int M1_B_SH    = 1;

    // Mode 2 over 2^7: R = 32+4, G = 64+8, B = 16-1
    localparam int M2_R_SH_HI = 5;
    localparam int M2_R_SH_LO = 2;
    localparam int M2_G_SH_HI = 6;
    localparam int M2_G_SH_LO = 3;
    localparam int M2_B_SH    = 4;

    function automatic int frac_width(input int mode);
        case (mode)
            MODE_MULT8:  return FRAC_MULT8;
            MODE_SHIFT4: return FRAC_SHIFT4;
            MODE_SHIFT7: return FRAC_SHIFT7;
            default:     return 0;
        endcase
    endfunction

    // Coefficients sum to at most 1, so COLORDEPTH+frac bits never overflow.
    function automatic int acc_width(input int colordepth, input int mode);
        return colordepth + frac_width(mode);
    endfunction

    function automatic bit mode_supported(input int mode);
        return (mode >= MODE_MULT8) && (mode <= MODE_SHIFT7);
    endfunction

endpackage

// File: rtl/rgb_to_luma_sig_delay.sv
// N-stage shift register with synchronous active-low reset; exposes the
// final stage and the one before it.
module sig_delay #(
    parameter int DATA_W = 3,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic [DATA_W-1:0] prev_o
);

    logic [DATA_W-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[STAGES-1];

    generate
        if (STAGES > 1) begin : g_prev_tap
            assign prev_o = stage_q[STAGES-2];
        end else begin : g_prev_input
            assign prev_o = data_i;
        end
    endgenerate

endmodule

// File: rtl/rgb_to_luma.sv
// Two-stage RGB-to-luma converter: weighted terms, then sum and floor.
// Video controls ride an identical two-stage delay to stay aligned.
module rgb_to_luma
    import rgb2y_pkg::*;
#(
    parameter int COLORDEPTH = 8,
    parameter int POWEREFF   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLORDEPTH-1:0] red_i,
    input  logic [COLORDEPTH-1:0] green_i,
    input  logic [COLORDEPTH-1:0] blue_i,
    input  logic                  dv_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [COLORDEPTH-1:0] gamma_o,
    output logic                  dv_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  line_end_o
);

    localparam int FW = frac_width(POWEREFF);
    localparam int AW = acc_width(COLORDEPTH, POWEREFF);

    function automatic logic [COLORDEPTH-1:0] floor_frac(input logic [AW-1:0] acc);
        return COLORDEPTH'(acc >> FW);
    endfunction

    logic [AW-1:0] r_ext, g_ext, b_ext;
    logic [AW-1:0] r_term_d, g_term_d, b_term_d;
    logic [AW-1:0] r_term_p1_q, g_term_p1_q, b_term_p1_q;
    logic [AW-1:0] sum_p2;
    logic [COLORDEPTH-1:0] gamma_d, gamma_q;

    assign r_ext = AW'(red_i);
    assign g_ext = AW'(green_i);
    assign b_ext = AW'(blue_i);

    generate
        if (POWEREFF == MODE_MULT8) begin : g_mult8
            always_comb begin
                r_term_d = r_ext * AW'(M0_COEF_R);
                g_term_d = g_ext * AW'(M0_COEF_G);
                b_term_d = b_ext * AW'(M0_COEF_B);
            end
        end else if (POWEREFF == MODE_SHIFT4) begin : g_shift4
            always_comb begin
                r_term_d = (r_ext << M1_R_SH_HI) + (r_ext << M1_R_SH_LO);
                g_term_d = (g_ext << M1_G_SH_HI) + (g_ext << M1_G_SH_LO);
                b_term_d = b_ext << M1_B_SH;
            end
        end else if (POWEREFF == MODE_SHIFT7) begin : g_shift7
            always_comb begin
                r_term_d = (r_ext << M2_R_SH_HI) + (r_ext << M2_R_SH_LO);
                g_term_d = (g_ext << M2_G_SH_HI) + (g_ext << M2_G_SH_LO);
                b_term_d = (b_ext << M2_B_SH) - b_ext;
            end
        end else begin : g_unsupported
            $error("rgb_to_luma: unsupported POWEREFF value %0d", POWEREFF);
            assign r_term_d = '0;
            assign g_term_d = '0;
            assign b_term_d = '0;
        end
    endgenerate

    // Stage 1: weighted partial products at full precision
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_term_p1_q <= '0;
            g_term_p1_q <= '0;
            b_term_p1_q <= '0;
        end else begin
            r_term_p1_q <= r_term_d;
            g_term_p1_q <= g_term_d;
            b_term_p1_q <= b_term_d;
        end
    end

    assign sum_p2  = r_term_p1_q + g_term_p1_q + b_term_p1_q;
    assign gamma_d = floor_frac(sum_p2);

    // Stage 2: summed, floored luma
    always_ff @(posedge clk) begin
        if (!rst) begin
            gamma_q <= '0;
        end else begin
            gamma_q <= gamma_d;
        end
    end

    assign gamma_o = gamma_q;

    logic [2:0] ctl_in, ctl_p2, ctl_p1;
    logic       unused_ctl_p1;

    assign ctl_in = {dv_i, hs_i, vs_i};

    sig_delay #(
        .DATA_W (3),
        .STAGES (2)
    ) u_ctl_delay (
        .clk    (clk),
        .rst    (rst),
        .data_i (ctl_in),
        .data_o (ctl_p2),
        .prev_o (ctl_p1)
    );

    assign dv_o = ctl_p2[2];
    assign hs_o = ctl_p2[1];
    assign vs_o = ctl_p2[0];

    // Last valid pixel: valid now, and the pixel one stage behind is not.
    assign line_end_o    = ctl_p2[2] & ~ctl_p1[2];
    assign unused_ctl_p1 = ^ctl_p1[1:0];

endmodule

// File: tb/tb_rgb_to_luma.sv
// Randomised scoreboard bench for rgb_to_luma (default mode 2, COLORDEPTH 8).
module tb_rgb_to_luma;

    logic       clk;
    logic       rst;
    logic [7:0] red, green, blue;
    logic       dv, hs, vs;
    logic [7:0] gamma;
    logic       dv_out, hs_out, vs_out, line_end;

    rgb_to_luma #(
        .COLORDEPTH (8),
        .POWEREFF   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .red_i      (red),
        .green_i    (green),
        .blue_i     (blue),
        .dv_i       (dv),
        .hs_i       (hs),
        .vs_i       (vs),
        .gamma_o    (gamma),
        .dv_o       (dv_out),
        .hs_o       (hs_out),
        .vs_o       (vs_out),
        .line_end_o (line_end)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int gam;
        bit dv;
        bit hs;
        bit vs;
        bit le;
    } exp_t;

    typedef struct {
        bit [7:0] r;
        bit [7:0] g;
        bit [7:0] b;
        bit       dv;
        bit       hs;
        bit       vs;
        bit       run;
        int       cg;
    } stim_t;

    exp_t  exp_q[$];
    stim_t prev;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 0;
    bit    vga_mode = 0;
    int    run_len = 0;
    int    le_cnt = 0;
    bit    prev_dv_out = 0;

    // Exact real-valued luma for mode 2, floored.
    function automatic int luma_ref(input bit [7:0] r, input bit [7:0] g, input bit [7:0] b);
        real exact;
        exact = real'(r) * (0.25 + 1.0 / 32.0)
              + real'(g) * (0.5 + 1.0 / 16.0)
              + real'(b) * (0.125 - 1.0 / 128.0);
        return int'($floor(exact));
    endfunction

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    // Drive one cycle and push the output expected after the coming edge.
    task automatic apply(input bit [7:0] r, input bit [7:0] g, input bit [7:0] b,
                         input bit d, input bit h, input bit v, input bit run, input int cg);
        exp_t  e;
        bit    ok;
        red   = r;
        green = g;
        blue  = b;
        dv    = d;
        hs    = h;
        vs    = v;
        rst   = run;
        ok    = prev.run && run;
        if (!ok)
            e.gam = 0;
        else if (prev.cg >= 0)
            e.gam = prev.cg;
        else
            e.gam = luma_ref(prev.r, prev.g, prev.b);
        e.dv = ok && prev.dv;
        e.hs = ok && prev.hs;
        e.vs = ok && prev.vs;
        e.le = e.dv && !(run && d);
        exp_q.push_back(e);
        prev = '{r: r, g: g, b: b, dv: d, hs: h, vs: v, run: run, cg: cg};
        @(posedge clk);
        #1;
    endtask

    task automatic apply_rand(input bit run);
        apply(8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)),
              1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), run, -1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("gamma", int'(gamma), e.gam);
                chk("dv_o", int'(dv_out), int'(e.dv));
                chk("hs_o", int'(hs_out), int'(e.hs));
                chk("vs_o", int'(vs_out), int'(e.vs));
                chk("line_end", int'(line_end), int'(e.le));
            end
            chk("line_end_without_dv", int'(line_end && !dv_out), 0);
            if (vga_mode) begin
                if (dv_out) begin
                    run_len++;
                    if (line_end) begin
                        le_cnt++;
                        chk("line_end_position", run_len, 64);
                    end
                end else if (prev_dv_out) begin
                    chk("line_end_per_line", le_cnt, 1);
                    run_len = 0;
                    le_cnt  = 0;
                end
            end else begin
                run_len = 0;
                le_cnt  = 0;
            end
            prev_dv_out = dv_out;
        end
    end

    typedef struct {
        bit [7:0] r;
        bit [7:0] g;
        bit [7:0] b;
        int       y;
    } dir_t;

    dir_t dir_tab[6] = '{
        '{8'hFF, 8'hFF, 8'hFF, 245},
        '{8'h80, 8'h00, 8'h00, 36},
        '{8'h00, 8'h80, 8'h00, 72},
        '{8'h00, 8'h00, 8'h80, 15},
        '{8'h01, 8'h01, 8'h01, 0},
        '{8'h00, 8'h00, 8'h00, 0}
    };

    initial begin
        bit [23:0] cnt;
        prev = '{r: 0, g: 0, b: 0, dv: 0, hs: 0, vs: 0, run: 0, cg: -1};
        mon_en = 1'b1;

        // Reset held with toggling inputs
        for (int i = 0; i < 10; i++) apply_rand(1'b0);

        foreach (dir_tab[i])
            apply(dir_tab[i].r, dir_tab[i].g, dir_tab[i].b, 1'b1, 1'b0, 1'b0, 1'b1, dir_tab[i].y);
        apply(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0);

        // Counter sweep starting from a reset release
        apply_rand(1'b0);
        cnt = '0;
        for (int i = 0; i < 3000; i++) begin
            apply(cnt[23:16], cnt[15:8], cnt[7:0], 1'($urandom_range(1)), 1'b0, 1'b0, 1'b1, -1);
            cnt = cnt + 24'd1;
        end

        // Fully random with occasional resets
        for (int i = 0; i < 1500; i++) apply_rand($urandom_range(63) != 0);

        // VGA frame: 64x64 visible, H 64+3+13+3, V 64+2+3+2
        for (int i = 0; i < 3; i++) apply_rand(1'b0);
        vga_mode = 1'b1;
        for (int y = 0; y < 71; y++) begin
            for (int x = 0; x < 83; x++) begin
                apply(8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)),
                      (y < 64) && (x < 64), (x >= 67) && (x < 80), (y >= 66) && (y < 69),
                      1'b1, -1);
            end
        end
        vga_mode = 1'b0;

        // Mid-line single-cycle reset
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 83; x++) begin
                apply(8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)),
                      x < 64, (x >= 67) && (x < 80), 1'b0, !(y == 0 && x == 20), -1);
            end
        end

        for (int i = 0; i < 4; i++) apply(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
